exu_regfile_pc: RTL and testbench
=================================

# exu_regfile_pc

Single-cycle execution slice of the ysyx_22041211 RV32 core. It holds the program-counter register, the 32×32 integer register file, and the combinational execute (ALU) unit. Writeback into the register file is also handled here. It sits between the decoder, which supplies register addresses, ALU control, immediate and destination, and the pcPlus adder, which supplies the next PC.

## Interface
- DATA_LEN, 32, datapath width
- ADDR_LEN, 32, PC width
- RESET_PC, 32'h8000_0000, PC value held during reset
- clk  in  1  single clock, rising-edge
- rst  in  1  reset; asynchronous, active-low
- pc_next  in  ADDR_LEN  next PC, loaded every cycle
- pc  out  ADDR_LEN  current PC
- raddr1, raddr2  in  5  register read addresses
- rdata1, rdata2  out  DATA_LEN  register read data; also drive the ALU operands
- aluop  in  4  ALU operation
- alusel  in  4  operand/result class
- imm  in  DATA_LEN  decoded immediate
- wd_i  in  1  instruction writes rd
- wreg_i  in  5  destination register
- wd_o  out  1  writeback enable (equals wd_i)
- wreg_o  out  5  writeback address (equals wreg_i)
- wdata_o  out  DATA_LEN  execute result

## Operation
- **PC register**
  - Loads pc_next on every rising edge while rst=1.
  - No stall or enable input.
- **Register file**
  - 32 entries of DATA_LEN bits.
  - Reads are combinational.
  - x0 always reads 0; any write to x0 is discarded.
  - A write occurs at the rising edge when wd_o=1 and wreg_o≠0, storing wdata_o.
- **alusel** selects the result class:
  - 0: R-type; src1=rdata1, src2=rdata2, result=ALU(aluop).
  - 1: I-type; src1=rdata1, src2=imm, result=ALU(aluop).
  - 2: LUI; result=imm.
  - 3: AUIPC; result=pc+imm.
  - 4: JAL/JALR link; result=pc+4.
  - All other values: result=0.
- **aluop** selects the ALU operation:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA (arithmetic), 8 OR, 9 AND.
  - Values 10–15 give 0.
- **Arithmetic rules**
  - Add/sub wrap modulo 2^32.
  - Shift amount is src2[4:0].
  - SLT/SLTU produce 32'd0 or 32'd1.
  - pc+4 and pc+imm wrap modulo 2^32.
- wd_o and wreg_o pass wd_i and wreg_i through unchanged; wdata_o is the result.

## Timing
- Execute path and register reads are purely combinational, with zero cycles of latency.
- Register write and PC update take effect at the same rising edge; the new values are visible after that edge.
- Without the bypass (see Configuration), a read of the register being written in the same cycle returns the old value.
- **Reset**
  - Asserting rst (0) immediately sets pc=RESET_PC and clears all registers to 0, independent of clk.
  - Outputs under reset: pc=RESET_PC, rdata1=rdata2=0, wd_o/wreg_o follow their inputs, wdata_o is combinational from cleared state.
  - Writes and PC loads are suppressed while rst=0; this includes reset asserted mid-operation.
  - The first PC load happens at the first rising edge after rst returns to 1.
- Simultaneous reset and clock edge: reset wins.

## Configuration
- RF_BYPASS_EN
  - Defined: if wd_o=1, wreg_o≠0 and raddrN==wreg_o, then rdataN returns wdata_o in the same cycle (write-to-read forwarding). The result path must not form a combinational loop; the bypass is applied only to externally observed rdataN, and ALU operands use the array value.
  - Undefined: no forwarding; a same-cycle read returns the stored value.

## Test plan
- **Reset:** rst=0 mid-cycle → pc=0x80000000 and every raddr reads 0 immediately. Release rst and drive pc_next=0x80000004 → after one edge pc=0x80000004.
- **ADDI into x1:** alusel=1, aluop=0, raddr1=0, imm=5, wd_i=1, wreg_i=1 → wdata_o=5 combinationally. After the edge, raddr1=1 reads 5.
- **Compare/subtract:** x1=5, x2=0xFFFFFFFD, alusel=0.
  - SUB gives 8.
  - SLT gives 0.
  - SLTU gives 1.
- **Shifts:** src1=0x80000000, imm=36, alusel=1.
  - SRA gives 0xF8000000.
  - SRL gives 0x08000000.
  - SLL gives 0.
- **x0 protection:** wd_i=1, wreg_i=0, result 0x1234 → after the edge, x0 still reads 0.
- **PC-relative classes:** pc=0x80000010, imm=0x1000.
  - LUI gives 0x00001000.
  - AUIPC gives 0x80001010.
  - Link gives 0x80000014.
  - Repeat the link case with pc=0xFFFFFFFC → wraps to 0x00000000.

Source files
------------

// File: rtl/exu_regfile_pc_if.sv
// rtl/exu_regfile_pc_if.sv - decoder/pc-adder side bundle of the execute slice
interface exu_regfile_pc_if #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
);
  logic [ADDR_LEN-1:0] pc_next;
  logic [ADDR_LEN-1:0] pc;
  logic [4:0]          raddr1;
  logic [4:0]          raddr2;
  logic [DATA_LEN-1:0] rdata1;
  logic [DATA_LEN-1:0] rdata2;
  logic [3:0]          aluop;
  logic [3:0]          alusel;
  logic [DATA_LEN-1:0] imm;
  logic                wd_i;
  logic [4:0]          wreg_i;
  logic                wd_o;
  logic [4:0]          wreg_o;
  logic [DATA_LEN-1:0] wdata_o;

  modport master (
    output pc_next, raddr1, raddr2, aluop, alusel, imm, wd_i, wreg_i,
    input  pc, rdata1, rdata2, wd_o, wreg_o, wdata_o
  );

  modport slave (
    input  pc_next, raddr1, raddr2, aluop, alusel, imm, wd_i, wreg_i,
    output pc, rdata1, rdata2, wd_o, wreg_o, wdata_o
  );
endinterface

// File: rtl/exu_regfile_pc.sv
// rtl/exu_regfile_pc.sv - PC register, 32x32 register file and ALU; optional RF_BYPASS_EN forwarding
module exu_regfile_pc #(
  parameter int              DATA_LEN = 32,
  parameter int              ADDR_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h8000_0000
) (
  input logic             clk,
  input logic             rst,
  exu_regfile_pc_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } aluop_e;

  typedef enum logic [3:0] {
    SEL_R     = 4'd0,
    SEL_I     = 4'd1,
    SEL_LUI   = 4'd2,
    SEL_AUIPC = 4'd3,
    SEL_LINK  = 4'd4
  } alusel_e;

  logic [ADDR_LEN-1:0] pc_q;
  logic [ADDR_LEN-1:0] pc_d;
  logic [DATA_LEN-1:0] rf_q [0:31];
  logic                rf_we_d;
  logic [DATA_LEN-1:0] rf_rd1;
  logic [DATA_LEN-1:0] rf_rd2;
  logic [DATA_LEN-1:0] src1;
  logic [DATA_LEN-1:0] src2;
  logic [DATA_LEN-1:0] alu_res;
  logic [DATA_LEN-1:0] result;
  logic [4:0]          shamt;

  assign pc_d    = bus.pc_next;
  assign rf_we_d = bus.wd_o && (bus.wreg_o != 5'd0);

  // PC advances to the externally computed next PC every cycle; reset forces the boot address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Register file: async clear, single write port; entry 0 is never written so x0 stays zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we_d) begin
      rf_q[bus.wreg_o] <= result;
    end
  end

  // Array reads feed the ALU directly so the bypass can never loop result back into itself
  assign rf_rd1 = (bus.raddr1 == 5'd0) ? '0 : rf_q[bus.raddr1];
  assign rf_rd2 = (bus.raddr2 == 5'd0) ? '0 : rf_q[bus.raddr2];

  assign src1  = rf_rd1;
  assign src2  = (bus.alusel == SEL_I) ? bus.imm : rf_rd2;
  assign shamt = src2[4:0];

  // ALU operation decode; unassigned opcodes yield zero
  always_comb begin
    alu_res = '0;
    case (aluop_e'(bus.aluop))
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_SLL:  alu_res = src1 << shamt;
      OP_SLT:  alu_res = {{(DATA_LEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU: alu_res = {{(DATA_LEN-1){1'b0}}, (src1 < src2)};
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SRL:  alu_res = src1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src1) >>> shamt);
      OP_OR:   alu_res = src1 | src2;
      OP_AND:  alu_res = src1 & src2;
      default: alu_res = '0;
    endcase
  end

  // Result class select: ALU, immediate, pc-relative or link address
  always_comb begin
    result = '0;
    case (alusel_e'(bus.alusel))
      SEL_R, SEL_I: result = alu_res;
      SEL_LUI:      result = bus.imm;
      SEL_AUIPC:    result = pc_q + bus.imm;
      SEL_LINK:     result = pc_q + 32'd4;
      default:      result = '0;
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.wd_o    = bus.wd_i;
  assign bus.wreg_o  = bus.wreg_i;
  assign bus.wdata_o = result;

`ifdef RF_BYPASS_EN
  // Forward the in-flight writeback value to external readers of the same register
  assign bus.rdata1 = (rf_we_d && (bus.raddr1 == bus.wreg_o)) ? result : rf_rd1;
  assign bus.rdata2 = (rf_we_d && (bus.raddr2 == bus.wreg_o)) ? result : rf_rd2;
`else
  assign bus.rdata1 = rf_rd1;
  assign bus.rdata2 = rf_rd2;
`endif

endmodule

// File: tb/tb_exu_regfile_pc.sv
// tb/tb_exu_regfile_pc.sv - directed scoreboard bench for exu_regfile_pc
module tb_exu_regfile_pc;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  exu_regfile_pc_if #(.DATA_LEN(32), .ADDR_LEN(32)) bus_if ();

  exu_regfile_pc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_val(input logic [31:0] observed);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (observed === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, observed, e);
      end
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [3:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] im, input logic wd,
                       input logic [4:0] wr);
    bus_if.alusel = sel;
    bus_if.aluop  = op;
    bus_if.raddr1 = r1;
    bus_if.raddr2 = r2;
    bus_if.imm    = im;
    bus_if.wd_i   = wd;
    bus_if.wreg_i = wr;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus_if.pc_next = 32'h8000_0004;
    drive(4'd0, 4'd0, 5'd5, 5'd31, 32'd0, 1'b0, 5'd0);

    // reset asserted mid-cycle takes effect without a clock edge
    #3 rst = 1'b0;
    #1;
    expect_val("reset_pc", 32'h8000_0000);   check_val(bus_if.pc);
    expect_val("reset_rdata1", 32'd0);       check_val(bus_if.rdata1);
    expect_val("reset_rdata2", 32'd0);       check_val(bus_if.rdata2);
    @(negedge clk);
    @(negedge clk);
    expect_val("reset_pc_hold", 32'h8000_0000); check_val(bus_if.pc);
    rst = 1'b1;
    @(negedge clk);
    expect_val("pc_first_load", 32'h8000_0004); check_val(bus_if.pc);

    // ADDI x1 = x0 + 5
    drive(4'd1, 4'd0, 5'd0, 5'd0, 32'd5, 1'b1, 5'd1);
    #1;
    expect_val("addi_wdata", 32'd5); check_val(bus_if.wdata_o);
    expect_val("addi_wd_o", 32'd1);  check_val({31'd0, bus_if.wd_o});
    expect_val("addi_wreg_o", 32'd1); check_val({27'd0, bus_if.wreg_o});
    @(negedge clk);
    drive(4'd1, 4'd0, 5'd1, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    expect_val("x1_readback", 32'd5); check_val(bus_if.rdata1);

    // ADDI x2 = x0 + 0xFFFFFFFD
    @(negedge clk);
    drive(4'd1, 4'd0, 5'd0, 5'd0, 32'hFFFF_FFFD, 1'b1, 5'd2);
    @(negedge clk);

    // R-type on x1=5, x2=-3
    drive(4'd0, 4'd1, 5'd1, 5'd2, 32'd0, 1'b0, 5'd0);
    #1; expect_val("x2_readback", 32'hFFFF_FFFD); check_val(bus_if.rdata2);
    expect_val("sub", 32'd8);                     check_val(bus_if.wdata_o);
    bus_if.aluop = 4'd3; #1; expect_val("slt", 32'd0);          check_val(bus_if.wdata_o);
    bus_if.aluop = 4'd4; #1; expect_val("sltu", 32'd1);         check_val(bus_if.wdata_o);
    bus_if.aluop = 4'd0; #1; expect_val("add_wrap", 32'd2);     check_val(bus_if.wdata_o);
    bus_if.aluop = 4'd5; #1; expect_val("xor", 32'hFFFF_FFF8);  check_val(bus_if.wdata_o);
    bus_if.aluop = 4'd8; #1; expect_val("or", 32'hFFFF_FFFD);   check_val(bus_if.wdata_o);
    bus_if.aluop = 4'd9; #1; expect_val("and", 32'd5);          check_val(bus_if.wdata_o);
    bus_if.aluop = 4'd12; #1; expect_val("aluop_undef", 32'd0); check_val(bus_if.wdata_o);

    // LUI x3 = 0x80000000, then shifts by imm=36 (shamt 4)
    @(negedge clk);
    drive(4'd2, 4'd0, 5'd0, 5'd0, 32'h8000_0000, 1'b1, 5'd3);
    @(negedge clk);
    drive(4'd1, 4'd7, 5'd3, 5'd0, 32'd36, 1'b0, 5'd0);
    #1; expect_val("sra", 32'hF800_0000); check_val(bus_if.wdata_o);
    bus_if.aluop = 4'd6; #1; expect_val("srl", 32'h0800_0000); check_val(bus_if.wdata_o);
    bus_if.aluop = 4'd2; #1; expect_val("sll", 32'd0);         check_val(bus_if.wdata_o);

    // x0 write is discarded
    @(negedge clk);
    drive(4'd2, 4'd0, 5'd0, 5'd3, 32'h0000_1234, 1'b1, 5'd0);
    #1; expect_val("x0_wdata", 32'h0000_1234); check_val(bus_if.wdata_o);
    @(negedge clk);
    drive(4'd0, 4'd0, 5'd0, 5'd3, 32'd0, 1'b0, 5'd0);
    #1; expect_val("x0_protect", 32'd0);       check_val(bus_if.rdata1);
    expect_val("x3_intact", 32'h8000_0000);    check_val(bus_if.rdata2);

    // same-cycle read of the register being written
    @(negedge clk);
    drive(4'd2, 4'd0, 5'd1, 5'd0, 32'h0000_0077, 1'b1, 5'd1);
    #1;
`ifdef RF_BYPASS_EN
    expect_val("same_cycle_read", 32'h0000_0077);
`else
    expect_val("same_cycle_read", 32'd5);
`endif
    check_val(bus_if.rdata1);
    @(negedge clk);
    drive(4'd0, 4'd0, 5'd1, 5'd0, 32'd0, 1'b0, 5'd0);
    #1; expect_val("x1_rewrite", 32'h0000_0077); check_val(bus_if.rdata1);

    // pc-relative classes at pc=0x80000010
    bus_if.pc_next = 32'h8000_0010;
    @(negedge clk);
    expect_val("pc_load", 32'h8000_0010); check_val(bus_if.pc);
    drive(4'd2, 4'd0, 5'd0, 5'd0, 32'h0000_1000, 1'b0, 5'd0);
    #1; expect_val("lui", 32'h0000_1000);   check_val(bus_if.wdata_o);
    bus_if.alusel = 4'd3; #1; expect_val("auipc", 32'h8000_1010); check_val(bus_if.wdata_o);
    bus_if.alusel = 4'd4; #1; expect_val("link", 32'h8000_0014);  check_val(bus_if.wdata_o);
    bus_if.alusel = 4'd7; #1; expect_val("alusel_undef", 32'd0);  check_val(bus_if.wdata_o);
    bus_if.pc_next = 32'hFFFF_FFFC;
    @(negedge clk);
    bus_if.alusel = 4'd4; #1; expect_val("link_wrap", 32'd0);     check_val(bus_if.wdata_o);

    // reset mid-operation suppresses the pending write and PC load
    @(negedge clk);
    drive(4'd2, 4'd0, 5'd1, 5'd5, 32'h0000_ABCD, 1'b1, 5'd5);
    #2 rst = 1'b0;
    #1;
    expect_val("midrst_pc", 32'h8000_0000); check_val(bus_if.pc);
    expect_val("midrst_x1", 32'd0);         check_val(bus_if.rdata1);
    expect_val("midrst_wd_o", 32'd1);       check_val({31'd0, bus_if.wd_o});
    expect_val("midrst_wdata", 32'h0000_ABCD); check_val(bus_if.wdata_o);
    @(negedge clk);
    expect_val("midrst_x5", 32'd0);         check_val(bus_if.rdata2);
    expect_val("midrst_pc_hold", 32'h8000_0000); check_val(bus_if.pc);
    bus_if.wd_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    expect_val("post_rst_pc", 32'hFFFF_FFFC); check_val(bus_if.pc);

    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
